// File: rtl/trace_pkg.sv
// Shared definitions for the trace player: trace characters, playback
// modes, state encoding and the character-extraction helper.
package trace_pkg;

    // Trace characters understood by the per-channel decoder
    localparam logic [7:0] CH_HIGH  = "-";
    localparam logic [7:0] CH_LOW   = "_";
    localparam logic [7:0] CH_ANY   = "?";
    localparam logic [7:0] CH_FIRST = "!";

    // Widest legal trace: 256 steps x 32 channels x 8 bits
    localparam int TRACE_MAXW = 8 * 256 * 32;

    typedef enum logic {
        TM_HOLD = 1'b0,
        TM_WRAP = 1'b1
    } trace_mode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PARK = 1'b1
    } play_state_e;

    // Character for channel c at step t. Channel 0 is the leftmost string
    // and step 0 is the leftmost character of that string. The trace is
    // passed zero-extended to the maximum width; len and channels give
    // the real geometry.
    function automatic logic [7:0] trace_char(
        input logic [TRACE_MAXW-1:0] trace,
        input int                    c,
        input int                    t,
        input int                    len,
        input int                    channels
    );
        return trace[8 * (len * (channels - c) - 1 - t) +: 8];
    endfunction

endpackage

// File: rtl/trace_decode.sv
// Combinational decode of one trace character into a channel level.
module trace_decode
    import trace_pkg::*;
(
    input  logic [7:0] ch,
    input  logic       any,
    input  logic       first,
    output logic       val
);

    // Map the character onto a level; unknown characters read as low
    always_comb begin
        // NOTE: assign a default before the case so no path leaves val
        // unassigned; otherwise synthesis infers a latch.
        val = 1'b0;
        case (ch)
            CH_HIGH:  val = 1'b1;
            CH_LOW:   val = 1'b0;
            CH_ANY:   val = any;
            CH_FIRST: val = first;
            default:  val = 1'b0;
        endcase
    end

endmodule

// File: rtl/trace_player.sv
// Multi-channel stimulus generator: plays compile-time character traces,
// one character per enabled clock step, in HOLD or WRAP mode.
module trace_player
    import trace_pkg::*;
#(
    parameter int                          CHANNELS = 4,
    parameter int                          LEN      = 32,
    parameter trace_mode_e                 MODE     = TM_HOLD,
    parameter int                          LOOPW    = 4,
    parameter logic [8*LEN*CHANNELS-1:0]   TRACE    = {(LEN*CHANNELS){CH_LOW}}
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     restart,
    input  logic [CHANNELS-1:0]      anyval,
    output logic [CHANNELS-1:0]      out,
    output logic [$clog2(LEN)-1:0]   step,
    output logic [LOOPW-1:0]         loops,
    output logic                     last,
    output logic                     done
);

    localparam int             SW        = $clog2(LEN);
    localparam logic [SW-1:0]  STEP_LAST = SW'(LEN - 1);

    play_state_e      state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [LOOPW-1:0] loops_q, loops_d;
    logic             first_pass;

    // State, step and pass-count registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            step_q  <= '0;
            loops_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state_q <= state_d;
            step_q  <= step_d;
            loops_q <= loops_d;
        end
    end

    // Next state: restart wins, otherwise advance while enabled in RUN
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        loops_d = loops_q;
        if (restart) begin
            state_d = ST_RUN;
            step_d  = '0;
            loops_d = '0;
        end else if (enable && state_q == ST_RUN) begin
            if (step_q == STEP_LAST) begin
                if (loops_q != '1) begin
                    loops_d = loops_q + LOOPW'(1);
                end
                if (MODE == TM_WRAP) begin
                    step_d = '0;
                end else begin
                    state_d = ST_PARK;
                end
            end else begin
                step_d = step_q + SW'(1);
            end
        end
    end

    assign step       = step_q;
    assign loops      = loops_q;
    assign last       = (step_q == STEP_LAST);
    assign first_pass = (loops_q == '0);
    // In HOLD the last step is terminal, so playback counts as parked as
    // soon as it is reached, one cycle before the pass is counted.
    assign done       = (MODE == TM_HOLD) && (state_q == ST_PARK || step_q == STEP_LAST);

    // Per-channel character table (constant) and decoder
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [7:0] chars [LEN];
        for (genvar t = 0; t < LEN; t++) begin : g_step
            assign chars[t] = trace_char(TRACE_MAXW'(TRACE), c, t, LEN, CHANNELS);
        end
        trace_decode u_decode (
            .ch    (chars[step_q]),
            .any   (anyval[c]),
            .first (first_pass),
            .val   (out[c])
        );
    end

endmodule

// File: tb/tb_trace_player.sv
// Scoreboard bench for trace_player: a HOLD instance (LEN=8) and a WRAP
// instance (LEN=5) run side by side from shared inputs against a model.
`timescale 1ns/1ps
module tb_trace_player;
    import trace_pkg::*;

    localparam logic [127:0] HOLD_TRACE = {"_-__--__", "??--?!_?"};
    localparam logic [79:0]  WRAP_TRACE = {"-!___", "?-?_!"};
    localparam int           LMAX       = 3;

    logic       clock   = 1'b0;
    logic       reset   = 1'b1;
    logic       enable  = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] anyval  = 2'b00;

    logic [1:0] h_out, w_out;
    logic [2:0] h_step, w_step;
    logic [1:0] h_loops, w_loops;
    logic       h_last, w_last, h_done, w_done;

    trace_player #(
        .CHANNELS(2), .LEN(8), .MODE(TM_HOLD), .LOOPW(2), .TRACE(HOLD_TRACE)
    ) u_hold (
        .clock(clock), .reset(reset), .enable(enable), .restart(restart),
        .anyval(anyval), .out(h_out), .step(h_step), .loops(h_loops),
        .last(h_last), .done(h_done)
    );

    trace_player #(
        .CHANNELS(2), .LEN(5), .MODE(TM_WRAP), .LOOPW(2), .TRACE(WRAP_TRACE)
    ) u_wrap (
        .clock(clock), .reset(reset), .enable(enable), .restart(restart),
        .anyval(anyval), .out(w_out), .step(w_step), .loops(w_loops),
        .last(w_last), .done(w_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int step;
        int loops;
        int done;
        int last;
        int out;
    } exp_t;

    exp_t  hold_q [$];
    exp_t  wrap_q [$];

    int    n_checks = 0;
    int    n_fail   = 0;

    // Reference model state, index 0 = HOLD instance, 1 = WRAP instance
    int    m_step  [2];
    int    m_loops [2];
    bit    m_park  [2];
    int    m_len   [2] = '{8, 5};
    bit    m_wrap  [2] = '{1'b0, 1'b1};
    string m_tr    [2][2];

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic bit m_dec(input byte ch, input bit any, input bit first);
        case (ch)
            "-":     return 1'b1;
            "?":     return any;
            "!":     return first;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 2; i++) begin
            m_step[i]  = 0;
            m_loops[i] = 0;
            m_park[i]  = 1'b0;
        end
    endfunction

    function automatic void m_advance(input int i, input bit en, input bit rs);
        if (rs) begin
            m_step[i]  = 0;
            m_loops[i] = 0;
            m_park[i]  = 1'b0;
        end else if (en && !m_park[i]) begin
            if (m_step[i] == m_len[i] - 1) begin
                if (m_loops[i] < LMAX) m_loops[i]++;
                if (m_wrap[i]) m_step[i] = 0;
                else           m_park[i] = 1'b1;
            end else begin
                m_step[i]++;
            end
        end
    endfunction

    function automatic exp_t m_expect(input int i);
        exp_t  e;
        string s;
        e.step  = m_step[i];
        e.loops = m_loops[i];
        e.last  = (m_step[i] == m_len[i] - 1) ? 1 : 0;
        e.done  = (!m_wrap[i] && e.last == 1) ? 1 : 0;
        e.out   = 0;
        for (int c = 0; c < 2; c++) begin
            s = m_tr[i][c];
            if (m_dec(s.getc(m_step[i]), anyval[c], m_loops[i] == 0))
                e.out = e.out | (1 << c);
        end
        return e;
    endfunction

    task automatic push_expected();
        hold_q.push_back(m_expect(0));
        wrap_q.push_back(m_expect(1));
    endtask

    task automatic cmp_fields(input string who, input exp_t e, input int st, input int lp,
                              input int dn, input int ls, input int o);
        check({who, "/step"},  st, e.step);
        check({who, "/loops"}, lp, e.loops);
        check({who, "/done"},  dn, e.done);
        check({who, "/last"},  ls, e.last);
        check({who, "/out"},   o,  e.out);
    endtask

    task automatic compare_pending(input string phase);
        exp_t e;
        check({phase, "/hold_sb_depth"}, hold_q.size(), 1);
        if (hold_q.size() > 0) begin
            e = hold_q.pop_front();
            cmp_fields({phase, "/hold"}, e, int'(h_step), int'(h_loops),
                       int'(h_done), int'(h_last), int'(h_out));
        end
        check({phase, "/wrap_sb_depth"}, wrap_q.size(), 1);
        if (wrap_q.size() > 0) begin
            e = wrap_q.pop_front();
            cmp_fields({phase, "/wrap"}, e, int'(w_step), int'(w_loops),
                       int'(w_done), int'(w_last), int'(w_out));
        end
    endtask

    // One clock step: drive on the falling edge, check 1 ns after rising edge
    task automatic cycle(input string phase, input bit en, input bit rs, input logic [1:0] av);
        @(negedge clock);
        enable  = en;
        restart = rs;
        anyval  = av;
        m_advance(0, en, rs);
        m_advance(1, en, rs);
        push_expected();
        @(posedge clock);
        #1;
        compare_pending(phase);
    endtask

    initial begin
        logic [1:0] av;
        m_tr[0][0] = "_-__--__";
        m_tr[0][1] = "??--?!_?";
        m_tr[1][0] = "-!___";
        m_tr[1][1] = "?-?_!";
        m_reset();

        // Reset state, checked while reset is held and after release
        repeat (2) @(posedge clock);
        #1;
        push_expected();
        compare_pending("in_reset");
        @(negedge clock);
        reset = 1'b0;
        #1;
        push_expected();
        compare_pending("reset");

        // Free run with anyval[1] toggling: HOLD parks, WRAP wraps twice
        for (int k = 0; k < 10; k++) begin
            av = (k % 2 == 0) ? 2'b10 : 2'b00;
            cycle("run", 1'b1, 1'b0, av);
        end

        // Restart while parked, advance to step 3, restart with enable
        cycle("restart_park", 1'b0, 1'b1, 2'b00);
        repeat (3) cycle("to_step3", 1'b1, 1'b0, 2'b10);
        cycle("restart_en", 1'b1, 1'b1, 2'b00);

        // Enable gating 1,0,0,1
        cycle("gate", 1'b1, 1'b0, 2'b01);
        cycle("gate", 1'b0, 1'b0, 2'b10);
        cycle("gate", 1'b0, 1'b0, 2'b11);
        cycle("gate", 1'b1, 1'b0, 2'b00);

        // Restart in WRAP's last-step cycle with loops already at 1
        cycle("restart", 1'b0, 1'b1, 2'b00);
        repeat (9) cycle("to_last", 1'b1, 1'b0, 2'(($urandom_range(0, 3))));
        cycle("restart_last", 1'b1, 1'b1, 2'b11);

        // Long run: WRAP pass counter saturates and keeps wrapping
        repeat (20) cycle("saturate", 1'b1, 1'b0, 2'(($urandom_range(0, 3))));

        // Async reset pulse between edges at step 6
        cycle("restart", 1'b0, 1'b1, 2'b00);
        repeat (6) cycle("to_step6", 1'b1, 1'b0, 2'b10);
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        push_expected();
        compare_pending("async_reset");
        reset = 1'b0;

        // Mixed random enable / restart / anyval
        for (int k = 0; k < 40; k++) begin
            cycle("random", $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_player.md
# trace_player

Parametrised multi-channel stimulus generator for formal and simulation benches of SVA property tests. Each output channel is driven from a compile-time character string, one character per clock step. Compared with the fixed four-channel, 32-step sequencer this block adds:
- configurable channel count and trace length;
- hold or wrap playback mode;
- a free-value character for formal;
- enable, restart, reset and progress outputs.

Sits beside the device/property under test inside each pass_/fail_ wrapper.

## Interface
- `CHANNELS`, default 4, number of output channels (1..32).
- `LEN`, default 32, trace length in steps (2..256).
- `MODE`, default 0: 0 = HOLD (stop at last step), 1 = WRAP (loop forever).
- `LOOPW`, default 4, width of the pass counter.
- `TRACE`, width `8*LEN*CHANNELS`, default all `"_"`.
  - Concatenated strings with channel 0 leftmost.
  - Channel c occupies `TRACE[8*LEN*(CHANNELS-c)-1 -: 8*LEN]`.
  - Step t of a channel is character `[8*(LEN-1-t) +: 8]` of its string, so step 0 is the leftmost character.

Ports:
- `clock`, in, 1: sole clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `enable`, in, 1: advance one step per cycle while high.
- `restart`, in, 1: synchronous return to step 0.
- `anyval`, in, `CHANNELS`: values used by `'?'` characters; tie to `$anyseq` in formal.
- `out`, out, `CHANNELS`: decoded channel values.
- `step`, out, `$clog2(LEN)`: current step index.
- `loops`, out, `LOOPW`: completed passes; saturates at all-ones.
- `last`, out, 1: `step == LEN-1`.
- `done`, out, 1: HOLD mode only, high once playback is parked on the last step.

## Operation
Character decode per channel, combinational from `step`:
- `'-'` gives 1; `'_'` gives 0; `'?'` gives `anyval[c]`.
- `'!'` gives 1 only while `loops == 0`, otherwise 0.
- Any other character gives 0.

State machine `RUN` / `PARK`:
- Reset state is `RUN`.
- `RUN`: when `enable` is high, `step` increments. At `step == LEN-1` with `enable` high:
  - HOLD: go to `PARK` with `step` held at LEN-1; `loops` increments.
  - WRAP: `step` goes to 0; `loops` increments (saturating); stay in `RUN`.
- `PARK`: `step` frozen; `done = 1`; `enable` is ignored.
- `restart` overrides `enable` and applies in any state: `step` ← 0, `loops` ← 0, state ← `RUN`.
- `enable` low: all state holds.
- `done` is 0 in WRAP mode, always.

## Timing
- `out` is valid in the same cycle as `step`, with zero latency from step to value. With `enable` held high from reset deassertion, the character at index k appears in cycle k.
- Reset values:
  - `step = 0`, `loops = 0`, state `RUN`, `done = 0`.
  - `last = (LEN-1 == 0)`, which is always 0 for legal LEN.
  - `out` = decode of step 0 (for `'!'` this is 1).
- Reset asserted mid-run clears everything immediately (asynchronously). The first advance happens on the first rising edge with reset low and `enable` high.
- `restart` and `enable` high in the same cycle: the next cycle shows step 0, and the restart cycle does not count as an advance.
- `restart` in the last-step cycle: `loops` is cleared, not incremented.
- Saturation: `loops` stays at `2**LOOPW-1`. In WRAP mode `step` keeps wrapping.
- Width rule: `step` increments modulo LEN, never reaching LEN, including when LEN is not a power of two.

## Structure
- Package `trace_pkg`:
  - character constants `CH_HIGH = "-"`, `CH_LOW = "_"`, `CH_ANY = "?"`, `CH_FIRST = "!"`;
  - enum `trace_mode_e {TM_HOLD, TM_WRAP}`;
  - function `trace_char(trace, c, t)` returning the 8-bit character.
- Sub-module `trace_decode`: a purely combinational, per-channel decode of (character, `anyval` bit, first-pass flag). It is instantiated `CHANNELS` times via generate.
- The top level holds the counter, the state machine and the `loops` logic.

## Test plan
- HOLD, LEN=8, channel 0 = `"_-__--__"`, `enable` = 1:
  - `out[0]` over cycles 0..7 = 0,1,0,0,1,1,0,0.
  - `step` = 7, `done` = 1 from cycle 7 onward; `loops` = 1 from cycle 8.
- WRAP, LEN=5 (not a power of two), channel 0 = `"-!___"`, `enable` = 1:
  - `step` sequence 0,1,2,3,4,0,1…
  - `out[0]` = 1,1,0,0,0 on pass 0, then 1,0,0,0,0 on later passes.
  - `loops` increments at each wrap.
- `'?'` channel:
  - `anyval[1]` toggling each cycle: `out[1]` follows `anyval[1]` exactly on `'?'` steps.
  - `anyval[1]` held at 0 on `'-'` steps: `out[1]` = 1.
- `enable` gating: enable pattern 1,0,0,1: `step` = 1,1,1,2 (step 1 repeats for two stalled cycles).
- `restart` at step 3 together with `enable`: next `step` = 0 and `loops` = 0. Restart in `PARK` (HOLD mode): `done` drops next cycle.
- Async `reset` pulse mid-cycle at step 6: `step`, `loops` and `done` clear without waiting for a clock edge, and `out` shows step-0 decode.
